// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR after the CIC decimator: one shared multiplier, optional decimate-by-2.
// Latency NUM_TAPS+1 cycles from the triggering strobe; triggers that arrive while busy are dropped and flagged in overrun.
module cic_comp_fir #(
  parameter int DATA_WIDTH_I = 16,
  parameter int DATA_WIDTH_O = 16,
  parameter int COEF_WIDTH   = 18,
  parameter int NUM_TAPS     = 8,
  parameter int DECIM        = 1
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH_I-1:0]         data_in,
  input  logic                            coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]     coef_addr,
  input  logic [COEF_WIDTH-1:0]           coef_data,
  output logic [DATA_WIDTH_O-1:0]         data_out,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            overrun
);

  localparam int TW    = $clog2(NUM_TAPS);
  localparam int BW    = $clog2(2 * NUM_TAPS);
  localparam int PW    = DATA_WIDTH_I + COEF_WIDTH;
  localparam int ACC_W = PW + TW;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (COEF_WIDTH - 3);
  localparam logic signed [ACC_W-1:0] MAX_O = (ACC_W'(1) << (DATA_WIDTH_O - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_O = -MAX_O - ACC_W'(1);
  localparam logic [COEF_WIDTH-1:0]   UNITY = COEF_WIDTH'(1) << (COEF_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state_q, state_d;

  logic signed [DATA_WIDTH_I-1:0] sbuf [2*NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]   coef [NUM_TAPS];
  logic [BW-1:0]                  wr_ptr, base, rd_addr;
  logic [TW-1:0]                  k;
  logic                           phase;
  logic                           trigger;
  logic signed [ACC_W-1:0]        acc, rnd;
  logic signed [PW-1:0]           prod;
  logic [DATA_WIDTH_O-1:0]        sat;

  // With DECIM=1 phase never leaves 0, so every strobe triggers.
  assign trigger = in_valid && (phase == (DECIM == 2));
  assign rd_addr = base - BW'(k);
  assign prod    = coef[k] * sbuf[rd_addr];
  assign busy    = (state_q != IDLE);
  assign rnd     = (acc + HALF) >>> (COEF_WIDTH - 2);

  always_comb begin
    sat = rnd[DATA_WIDTH_O-1:0];
    if (rnd > MAX_O)      sat = MAX_O[DATA_WIDTH_O-1:0];
    else if (rnd < MIN_O) sat = MIN_O[DATA_WIDTH_O-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = MAC;
      MAC:     if (k == TW'(NUM_TAPS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < 2 * NUM_TAPS; i++) sbuf[i] <= '0;
      for (int i = 0; i < NUM_TAPS; i++)     coef[i] <= (i == 0) ? UNITY : '0;
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      phase     <= 1'b0;
      acc       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // The sample is always captured, even when its trigger is dropped.
      if (in_valid) begin
        sbuf[wr_ptr] <= data_in;
        wr_ptr       <= wr_ptr + BW'(1);
        if (DECIM == 2) phase <= ~phase;
      end
      if (trigger && state_q != IDLE) overrun <= 1'b1;
      if (coef_we && state_q == IDLE) coef[coef_addr] <= coef_data;
      case (state_q)
        IDLE: if (trigger) begin
          base <= wr_ptr;
          acc  <= '0;
          k    <= '0;
        end
        MAC: begin
          acc <= acc + $signed({{(ACC_W - PW){prod[PW-1]}}, prod});
          k   <= k + TW'(1);
        end
        DONE: begin
          data_out  <= sat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Compensation FIR stage directly downstream of the CIC decimator. It accepts the CIC output sample and its one-cycle strobe, corrects the CIC passband droop with a programmable NUM_TAPS-tap FIR, and optionally decimates by DECIM. A single time-multiplexed multiplier computes each output. Its output drives the next stage at the final decimated rate.

## Interface
- DATA_WIDTH_I, 16: signed input sample width; matches the CIC output width.
- DATA_WIDTH_O, 16: signed output sample width.
- COEF_WIDTH, 18: signed coefficient width. Unity gain is 2^(COEF_WIDTH-2).
- NUM_TAPS, 8: number of FIR taps. Must be a power of two and at least 2.
- DECIM, 1: output decimation factor. Allowed values are 1 and 2.

Ports:
- clk, input, 1: the single clock.
- arst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: one-cycle sample strobe. Driven by the CIC data_clk.
- data_in, input, DATA_WIDTH_I: signed sample. Valid while in_valid is high.
- coef_we, input, 1: coefficient write strobe.
- coef_addr, input, clog2(NUM_TAPS): index of the tap to write.
- coef_data, input, COEF_WIDTH: signed coefficient value.
- data_out, output, DATA_WIDTH_O: signed filtered sample. Registered and held until the next output.
- out_valid, output, 1: one-cycle pulse marking a new data_out.
- busy, output, 1: high while a MAC is in progress.
- overrun, output, 1: sticky flag for a dropped trigger. Cleared only by reset.

## Operation
- Sample buffer:
  - Circular buffer of depth 2*NUM_TAPS.
  - Every in_valid writes data_in at wr_ptr, then wr_ptr increments with wrap.
  - Writes happen regardless of state, including while busy.
- Decimation phase:
  - The phase counter advances modulo DECIM on every in_valid.
  - A trigger occurs on in_valid when phase == DECIM-1. With DECIM=1, every sample triggers.
- FSM states: IDLE, MAC, DONE.
  - IDLE: on a trigger, latch base = the address just written, clear acc, set k=0, and go to MAC.
  - MAC: acc += coef[k] * buf[base-k], with wrap on the buffer address; k increments each cycle. After k = NUM_TAPS-1, go to DONE.
  - DONE: register data_out, pulse out_valid, and return to IDLE.
- A trigger arriving in MAC or DONE is dropped. It sets overrun, but its sample is still written.
- busy = (state != IDLE).
- Arithmetic:
  - acc is signed, with width DATA_WIDTH_I + COEF_WIDTH + clog2(NUM_TAPS).
  - Result = (acc + 2^(COEF_WIDTH-3)) >>> (COEF_WIDTH-2). This is round half up.
  - The result saturates to [-2^(DATA_WIDTH_O-1), 2^(DATA_WIDTH_O-1)-1].
- Coefficients:
  - coef_we writes coef[coef_addr] only when busy is low. Writes while busy are ignored.
  - Reset values: coef[0] = 2^(COEF_WIDTH-2), which is identity; all other taps are 0.
- Reset (arst high):
  - Outputs: data_out=0, out_valid=0, busy=0, overrun=0.
  - Internal: buffer=0, wr_ptr=0, phase=0, acc=0, state=IDLE.
  - Reset asserted mid-MAC aborts the computation immediately. No out_valid is produced.

## Timing
- The edge that samples a trigger is E0. MAC accumulates on edges E1..E_NUM_TAPS.
- data_out and out_valid update on edge E_(NUM_TAPS+1). Latency is NUM_TAPS+1 cycles; with the defaults, out_valid is high in the 9th cycle after the in_valid cycle.
- out_valid stays high for exactly one cycle.
- busy rises after E0 and falls after E_(NUM_TAPS+1).
- Minimum trigger spacing without overrun is NUM_TAPS+2 cycles. With the defaults, CIC ratio 8 plus DECIM=2 meets this.
- Buffer safety: at most NUM_TAPS+1 samples can be written during one computation, so the window [base-NUM_TAPS+1, base] is never overwritten.
- A coefficient write and a trigger on the same edge while IDLE: the write lands first, and the MAC uses the new value.

## Test plan
- Reset: assert arst, then check data_out=0, out_valid=0, busy=0, overrun=0. Release arst, wait 20 cycles, and check no out_valid pulse occurs.
- Identity, DECIM=1: in_valid with 100, then -2048, spaced 12 cycles apart. Required: out_valid 9 cycles after each, with data_out=100, then -2048.
- Moving average: write all 8 taps to 8192, then feed a step of 800 every 12 cycles. Required: outputs 100, 200, ..., 800, then holding at 800.
- Rounding and saturation:
  - coef[0]=32768 with input 3 gives 2; input -3 gives -1.
  - coef[0]=coef[1]=65536 with inputs 30000, 30000 gives 32767.
  - Inputs -30000, -30000 give -32768.
- Overrun: two in_valid pulses 4 cycles apart. Required: one out_valid only and overrun=1, which stays set. The next trigger 12 cycles later computes normally over a window that includes the dropped sample.
- DECIM=2 and reset mid-MAC:
  - Feed 4 samples spaced 12 cycles apart. Required: out_valid only after samples 2 and 4.
  - Assert arst 3 cycles into a MAC. Required: busy=0 immediately and no out_valid.
